seg7_scan_display: RTL and testbench
====================================

// Module: seg7_scan_display
// PURPOSE
//  Parametrised multiplexed 7-segment display controller for the pipelined ARM top level.
//  Selects one of NUM_CHANNELS debug words (e.g. R0, R1, PC) and snapshots it on a load strobe.
//  Shows the snapshot in hex, or in decimal via a sequential double-dabble converter.
//  Scans NUM_DIGITS anodes at a programmable refresh rate and supports leading-zero blanking.
// PARAMETERS
//  DATA_WIDTH   16     width of each channel word
//  NUM_DIGITS   4      number of digits / anodes (>=1)
//  NUM_CHANNELS 2      number of selectable input words (>=1)
//  SCAN_DIV     50000  clk cycles per digit slot (>=1)
//  SELW = max(1,$clog2(NUM_CHANNELS)) (localparam); BCDW = ceil(DATA_WIDTH/3) BCD digits internal
// PORTS
//  clk      in   1                        system clock, rising edge
//  reset    in   1                        asynchronous, active-low (0 = reset)
//  ch_data  in   NUM_CHANNELS*DATA_WIDTH  packed channel words; channel k = [k*DATA_WIDTH +: DATA_WIDTH]
//  ch_sel   in   SELW                     channel select; values >= NUM_CHANNELS select channel 0
//  load     in   1                        snapshot request, sampled each edge
//  dec_mode in   1                        1 = decimal, 0 = hex; sampled with load
//  blank_lz in   1                        1 = blank leading zeros; used live, not latched
//  busy     out  1                        conversion in progress, load ignored
//  ovf      out  1                        committed value does not fit in NUM_DIGITS
//  seg      out  7                        {g,f,e,d,c,b,a}, active-low, registered
//  an       out  NUM_DIGITS               one-hot active-low anode enables, registered
// BEHAVIOUR
//  Reset (async, reset=0): FSM IDLE; busy=0; ovf=0; snapshot and digits=0; prescaler=0; idx=0;
//   seg=7'h7F; an=all ones. Outputs stay blank until the first scan tick after release.
//  FSM: IDLE, SHIFT, DONE.
//   IDLE: at an edge with load=1, latch word=ch_data[ch_sel] and mode=dec_mode; go to DONE in hex mode,
//    or to SHIFT in decimal mode with bcd=0 and cnt=DATA_WIDTH. busy=1 in every state except IDLE.
//   SHIFT: each cycle, add 3 to every BCD nibble >=5, then shift {bcd,word} left 1; cnt--; go to DONE
//    after DATA_WIDTH shifts.
//   DONE: commit digits[] and ovf in one edge (atomic, never a partial value shown); go to IDLE.
//  Latency from the load edge: hex commit +1 edge (busy high 1 cycle);
//   decimal commit +DATA_WIDTH+1 edges (busy high DATA_WIDTH+1 cycles).
//  load while busy is dropped, not queued. load in the same cycle busy falls is also dropped,
//   because the FSM is not yet in IDLE.
//  Overflow:
//   hex: ovf=1 when any word bit at or above 4*NUM_DIGITS is 1.
//   dec: ovf=1 when any BCD digit at or above NUM_DIGITS is nonzero.
//   While ovf=1, every digit shows '-' (seg=7'h3F) and blanking is ignored.
//  Digit values: low NUM_DIGITS hex nibbles or BCD digits; digit 0 is least significant (rightmost).
//  Decode 0-F with standard patterns (b and d lowercase). Examples: '0'=7'h40, '7'=7'h78, 'F'=7'h0E.
//  Leading-zero blanking: when blank_lz=1 and ovf=0, a digit i>0 is blanked (seg=7'h7F) if digit i
//   and all higher digits are 0. Digit 0 is never blanked. an still cycles for blanked digits.
//  Scan: prescaler counts 0..SCAN_DIV-1 and wraps. At the wrap edge, idx advances 0..NUM_DIGITS-1 and wraps.
//   At that same edge, an and seg register the new idx, so they change together and never glitch
//   across digits. The scan runs continuously, independent of the FSM.
//  NUM_DIGITS=1: idx stays 0; an=1'b0 after the first tick.
//  Reset mid-conversion: the FSM aborts to IDLE and all state is cleared; nothing is committed.
// TESTING (DATA_WIDTH=16, NUM_DIGITS=4, NUM_CHANNELS=2, SCAN_DIV=4)
//  1. Hex: ch1=16'hBEEF, ch_sel=1, load 1 cycle -> busy 1 cycle; digits 3..0 = b,E,E,F
//     (seg 7'h03,7'h06,7'h06,7'h0E); ovf=0.
//  2. Decimal: ch0=16'd1234, dec_mode=1 -> busy exactly 17 cycles; digits 3..0 = 1,2,3,4; ovf=0.
//  3. Decimal overflow: 16'd12345 -> ovf=1 and every digit seg=7'h3F;
//     then load 16'd9999 -> ovf=0, digits 9,9,9,9.
//  4. Blanking: dec 16'd7 with blank_lz=1 -> digit0 7'h78, digits 1-3 7'h7F.
//     Toggle blank_lz=0 -> '0' (7'h40) on digits 1-3 with no reload.
//  5. Load while busy: load 1234 (dec), then load 16'hFFFF 5 cycles later -> second load ignored,
//     1234 committed. Reset low at cycle 8 -> busy=0 at once; an/seg all ones.
//  6. Scan: an sequence 1110,1101,1011,0111,1110, one step every 4 clocks;
//     an and seg change on the same edge.

Source files
------------

// File: rtl/seg7_scan_display.sv
// seg7_scan_display
// Multiplexed 7-segment display controller. A selected channel word is
// snapshotted on load and shown either in hex or in decimal (via a sequential
// double-dabble converter). Committed digits are scanned across NUM_DIGITS
// active-low anodes at a rate of one digit slot every SCAN_DIV clocks.
module seg7_scan_display #(
  parameter int  DATA_WIDTH   = 16,
  parameter int  NUM_DIGITS   = 4,
  parameter int  NUM_CHANNELS = 2,
  parameter int  SCAN_DIV     = 50000,
  localparam int SELW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data,
  input  logic [SELW-1:0]                    ch_sel,
  input  logic                               load,
  input  logic                               dec_mode,
  input  logic                               blank_lz,
  output logic                               busy,
  output logic                               ovf,
  output logic [6:0]                         seg,
  output logic [NUM_DIGITS-1:0]              an
);

  localparam int BCDW = (DATA_WIDTH + 2) / 3;
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW   = $clog2(DATA_WIDTH + 1);
  localparam int XW   = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] word, word_n, sel_word;
  logic [4*BCDW-1:0]     bcd, bcd_n, bcd_adj;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  mode, mode_n;
  logic                  commit;
  logic [3:0]            digits     [NUM_DIGITS];
  logic [3:0]            new_digits [NUM_DIGITS];
  logic                  new_ovf;
  logic [XW+DATA_WIDTH-1:0] hex_ext;
  logic [XW+4*BCDW-1:0]     dec_ext;

  logic [PW-1:0]         presc;
  logic [IDXW-1:0]       idx, idx_n;
  logic                  tick;
  logic [NUM_DIGITS-1:0] lz;
  logic [6:0]            seg_n;

  // Active-low {g,f,e,d,c,b,a} patterns, b and d in lowercase.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Channel mux; out-of-range selects fall back to channel 0.
  always_comb begin
    sel_word = ch_data[DATA_WIDTH-1:0];
    for (int k = 1; k < NUM_CHANNELS; k++)
      if (int'(ch_sel) == k) sel_word = ch_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    for (int j = 0; j < BCDW; j++)
      bcd_adj[4*j +: 4] = (bcd[4*j +: 4] >= 4'd5) ? bcd[4*j +: 4] + 4'd3 : bcd[4*j +: 4];
  end

  // Conversion FSM next-state logic.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_n = state;
    word_n  = word;
    bcd_n   = bcd;
    cnt_n   = cnt;
    mode_n  = mode;
    commit  = 1'b0;
    case (state)
      IDLE: if (load) begin
        word_n  = sel_word;
        mode_n  = dec_mode;
        bcd_n   = '0;
        cnt_n   = CW'(DATA_WIDTH);
        state_n = dec_mode ? SHIFT : DONE;
      end
      SHIFT: begin
        {bcd_n, word_n} = {bcd_adj, word} << 1;
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) state_n = DONE;
      end
      DONE: begin
        commit  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Digit values and overflow derived from the finished snapshot.
  always_comb begin
    hex_ext = {{XW{1'b0}}, word};
    dec_ext = {{XW{1'b0}}, bcd};
    for (int i = 0; i < NUM_DIGITS; i++)
      new_digits[i] = mode ? dec_ext[4*i +: 4] : hex_ext[4*i +: 4];
    new_ovf = mode ? |(dec_ext >> XW) : |(hex_ext >> XW);
  end

  // FSM state and atomic commit of digits/ovf.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      word  <= '0;
      bcd   <= '0;
      cnt   <= '0;
      mode  <= 1'b0;
      ovf   <= 1'b0;
      // NOTE: the digit array is a handful of flops, not a RAM, so it is
      // reset element-wise like any other register.
      for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= 4'd0;
    end else begin
      state <= state_n;
      word  <= word_n;
      bcd   <= bcd_n;
      cnt   <= cnt_n;
      mode  <= mode_n;
      if (commit) begin
        digits <= new_digits;
        ovf    <= new_ovf;
      end
    end
  end

  assign busy = (state != IDLE);
  assign tick = (presc == PW'(SCAN_DIV - 1));

  // Next scan index and leading-zero map (lz[i]: digit i and all above are 0).
  always_comb begin
    idx_n = (idx == IDXW'(NUM_DIGITS - 1)) ? '0 : idx + IDXW'(1);
    lz    = '0;
    lz[NUM_DIGITS-1] = (digits[NUM_DIGITS-1] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--)
      lz[i] = lz[i+1] && (digits[i] == 4'd0);
  end

  // Segment pattern for the digit about to be selected.
  always_comb begin
    if (ovf)                                      seg_n = 7'h3F;
    else if (blank_lz && idx_n != '0 && lz[idx_n]) seg_n = 7'h7F;
    else                                          seg_n = hex_to_seg(digits[idx_n]);
  end

  // Scan prescaler; anode and segments update together on the wrap edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      idx   <= '0;
      an    <= '1;
      seg   <= 7'h7F;
    end else if (tick) begin
      presc <= '0;
      idx   <= idx_n;
      an    <= ~(NUM_DIGITS'(1) << idx_n);
      seg   <= seg_n;
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display
// Randomized and directed stimulus checked every cycle against a behavioural
// model built from plain arithmetic (division / nibble extraction, cycle
// countdowns), plus directed digit-pattern checks.
module tb_seg7_scan_display;

  localparam int DW = 16;
  localparam int ND = 4;
  localparam int NC = 2;
  localparam int SD = 4;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic             clk = 1'b0;
  logic             reset;
  logic [NC*DW-1:0] ch_data;
  logic             ch_sel;
  logic             load;
  logic             dec_mode;
  logic             blank_lz;
  logic             busy;
  logic             ovf;
  logic [6:0]       seg;
  logic [ND-1:0]    an;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  int            m_left;
  int            m_pend_val;
  bit            m_pend_dec;
  int            m_val;
  bit            m_dec;
  int            m_presc;
  int            m_idx;
  logic [6:0]    m_seg;
  logic [ND-1:0] m_an;

  logic [6:0] shown [ND];

  always #5 clk = ~clk;

  seg7_scan_display #(
    .DATA_WIDTH(DW), .NUM_DIGITS(ND), .NUM_CHANNELS(NC), .SCAN_DIV(SD)
  ) dut (
    .clk(clk), .reset(reset), .ch_data(ch_data), .ch_sel(ch_sel), .load(load),
    .dec_mode(dec_mode), .blank_lz(blank_lz), .busy(busy), .ovf(ovf),
    .seg(seg), .an(an)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int digit_of(input int i);
    int p = 1;
    if (!m_dec) return (m_val >> (4 * i)) & 15;
    for (int k = 0; k < i; k++) p = p * 10;
    return (m_val / p) % 10;
  endfunction

  function automatic bit model_ovf();
    int lim = 1;
    if (!m_dec) return m_val >= (1 << (4 * ND));
    for (int k = 0; k < ND; k++) lim = lim * 10;
    return m_val >= lim;
  endfunction

  function automatic logic [6:0] exp_seg(input int i);
    bit all_zero = 1'b1;
    if (model_ovf()) return 7'h3F;
    for (int j = i; j < ND; j++) if (digit_of(j) != 0) all_zero = 1'b0;
    if (blank_lz && i > 0 && all_zero) return 7'h7F;
    return SEG_TAB[digit_of(i)];
  endfunction

  task automatic model_reset();
    m_left  = 0;
    m_val   = 0;
    m_dec   = 1'b0;
    m_presc = 0;
    m_idx   = 0;
    m_seg   = 7'h7F;
    m_an    = '1;
  endtask

  // Advances the model by one clock edge using the inputs about to be sampled.
  task automatic model_edge();
    int s;
    if (!reset) begin
      model_reset();
      return;
    end
    if (m_presc == SD - 1) begin
      m_presc = 0;
      m_idx   = (m_idx + 1) % ND;
      m_an    = '1;
      m_an[m_idx] = 1'b0;
      m_seg   = exp_seg(m_idx);
    end else begin
      m_presc++;
    end
    if (m_left == 0) begin
      if (load) begin
        s = int'(ch_sel);
        if (s >= NC) s = 0;
        m_pend_val = int'(ch_data[s*DW +: DW]);
        m_pend_dec = dec_mode;
        m_left     = dec_mode ? DW + 1 : 1;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_val = m_pend_val;
        m_dec = m_pend_dec;
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check("busy", 32'(busy), 32'(m_left != 0));
    check("ovf",  32'(ovf),  32'(model_ovf()));
    check("an",   32'(an),   32'(m_an));
    check("seg",  32'(seg),  32'(m_seg));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Runs two full scan periods and records the pattern seen on each anode.
  task automatic show_all();
    for (int i = 0; i < ND; i++) shown[i] = 7'hxx;
    for (int c = 0; c < 2 * ND * SD; c++) begin
      cycle();
      for (int i = 0; i < ND; i++) if (an[i] == 1'b0) shown[i] = seg;
    end
  endtask

  task automatic do_load(input int ch, input logic [DW-1:0] v, input logic dm);
    ch_data[ch*DW +: DW] = v;
    ch_sel   = ch[0];
    dec_mode = dm;
    load     = 1'b1;
    cycle();
    load     = 1'b0;
  endtask

  task automatic check_shown(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                             input logic [6:0] d1, input logic [6:0] d0);
    check({tag, "_d3"}, 32'(shown[3]), 32'(d3));
    check({tag, "_d2"}, 32'(shown[2]), 32'(d2));
    check({tag, "_d1"}, 32'(shown[1]), 32'(d1));
    check({tag, "_d0"}, 32'(shown[0]), 32'(d0));
  endtask

  initial begin
    int n;
    logic [ND-1:0] prev_an;
    logic [ND-1:0] scan_seq [4];
    logic [DW-1:0] r;

    reset = 1'b1; load = 1'b0; dec_mode = 1'b0; blank_lz = 1'b0;
    ch_sel = 1'b0; ch_data = '0;
    model_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    check("rst_an",   32'(an),   32'hF);
    check("rst_seg",  32'(seg),  32'h7F);
    run(2);
    reset = 1'b1;
    run(3);

    // Hex snapshot of channel 1
    do_load(1, 16'hBEEF, 1'b0);
    check("hex_busy", 32'(busy), 32'd1);
    show_all();
    check("hex_ovf", 32'(ovf), 32'd0);
    check_shown("hex", 7'h03, 7'h06, 7'h06, 7'h0E);

    // Decimal 1234 with busy duration
    do_load(0, 16'd1234, 1'b1);
    n = 1;
    while (busy && n < 40) begin
      cycle();
      if (busy) n++;
    end
    check("dec_busy_len", 32'(n), 32'd17);
    show_all();
    check_shown("dec1234", 7'h79, 7'h24, 7'h30, 7'h19);

    // Decimal overflow then recovery
    do_load(0, 16'd12345, 1'b1);
    run(20);
    check("ovf_set", 32'(ovf), 32'd1);
    show_all();
    check_shown("ovf", 7'h3F, 7'h3F, 7'h3F, 7'h3F);
    do_load(0, 16'd9999, 1'b1);
    run(20);
    check("ovf_clr", 32'(ovf), 32'd0);
    show_all();
    check_shown("dec9999", 7'h10, 7'h10, 7'h10, 7'h10);

    // Leading-zero blanking, then live disable
    blank_lz = 1'b1;
    do_load(0, 16'd7, 1'b1);
    run(20);
    show_all();
    check_shown("blank", 7'h7F, 7'h7F, 7'h7F, 7'h78);
    blank_lz = 1'b0;
    show_all();
    check_shown("noblank", 7'h40, 7'h40, 7'h40, 7'h78);

    // Load while busy is dropped
    do_load(0, 16'd1234, 1'b1);
    run(4);
    do_load(1, 16'hFFFF, 1'b0);
    run(20);
    show_all();
    check_shown("drop", 7'h79, 7'h24, 7'h30, 7'h19);

    // Reset in the middle of a conversion
    do_load(0, 16'd4321, 1'b1);
    run(7);
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_an",   32'(an),   32'hF);
    check("midrst_seg",  32'(seg),  32'h7F);
    cycle();
    reset = 1'b1;
    run(20);
    show_all();
    check_shown("after_rst", 7'h40, 7'h40, 7'h40, 7'h40);

    // Scan order and step period
    scan_seq[0] = 4'b1101; scan_seq[1] = 4'b1011; scan_seq[2] = 4'b0111; scan_seq[3] = 4'b1110;
    n = 0;
    prev_an = an;
    while (!(an == 4'b1110 && prev_an != 4'b1110) && n < 4 * ND * SD) begin
      prev_an = an;
      cycle();
      n++;
    end
    check("scan_sync", 32'(an), 32'b1110);
    for (int s = 0; s < 4; s++) begin
      prev_an = an;
      n = 0;
      while (an == prev_an && n < 2 * SD) begin
        cycle();
        n++;
      end
      check("scan_period", 32'(n), 32'(SD));
      check("scan_an", 32'(an), 32'(scan_seq[s]));
    end

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      case ($urandom_range(0, 3))
        0:       r = DW'($urandom_range(0, 20));
        1:       r = DW'($urandom_range(0, 9999));
        2:       r = DW'($urandom_range(0, 255));
        default: r = DW'($urandom);
      endcase
      ch_data[($urandom_range(0, NC - 1))*DW +: DW] = r;
      ch_sel   = 1'($urandom_range(0, 1));
      dec_mode = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      cycle();
    end
    load = 1'b0;
    run(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
